// File: rtl/keylock_sender.sv
// keylock_sender: two-beat digit frame transmitter for the keylock link.
// Three data lines plus a strobe, with registered outputs throughout.
module keylock_sender #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic [3:0] num,
  input  logic       enabled,
  output logic       out0,
  output logic       out1,
  output logic       out2,
  output logic       controlOut,
  output logic       active,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       beat_q, beat_d;
  logic [3:0] n_q, n_d;
  logic       armed_q, armed_d;
  logic [2:0] data_q, data_d;
  logic       ctrl_q, ctrl_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
  logic [2:0] sym;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    beat_d  = beat_q;
    n_d     = n_q;
    armed_d = armed_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (enabled && armed_q) begin
          n_d     = num;
          armed_d = 1'b0;
          beat_d  = 1'b0;
          state_d = SETUP;
        end else if (!enabled) begin
          armed_d = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = 8'd0;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          cnt_d   = 8'd0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = 8'd0;
          if (!beat_q) begin
            beat_d  = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
    endcase

    // Outputs decode the next state so they are registered yet cycle-exact
    sym      = beat_d ? {^n_d, 1'b1, n_d[3]} : n_d[2:0];
    active_d = (state_d == SETUP) || (state_d == STROBE)
            || (state_d == HOLD);
    ctrl_d   = (state_d == STROBE);
    done_d   = (state_d == DONE);
    data_d   = active_d ? sym : 3'b000;
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      beat_q   <= 1'b0;
      n_q      <= 4'd0;
      armed_q  <= 1'b0;
      data_q   <= 3'b000;
      ctrl_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      n_q      <= n_d;
      armed_q  <= armed_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign out0       = data_q[0];
  assign out1       = data_q[1];
  assign out2       = data_q[2];
  assign controlOut = ctrl_q;
  assign active     = active_q;
  assign done       = done_q;

endmodule

// File: tb/tb_keylock_sender.sv
// tb_keylock_sender: scenario tasks plus randomized traffic checked
// against a frame-offset reference model of the keylock sender.
module tb_keylock_sender;

  localparam int S    = 2;
  localparam int ST   = 2;
  localparam int H    = 1;
  localparam int BEAT = S + ST + H;

  logic       hwclk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] num;
  logic       out0, out1, out2, ctrl, active, done;
  logic [5:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_t;
  logic       m_armed;
  logic [3:0] m_n;

  keylock_sender #(
    .SETUP_CYCLES (S),
    .STROBE_CYCLES(ST),
    .HOLD_CYCLES  (H)
  ) dut (
    .hwclk     (hwclk),
    .reset     (rst),
    .num       (num),
    .enabled   (en),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .controlOut(ctrl),
    .active    (active),
    .done      (done)
  );

  always #5 hwclk = ~hwclk;

  assign obs = {done, active, ctrl, out2, out1, out0};

  // {done, active, strobe, out2, out1, out0} expected after offset m_t
  function automatic logic [5:0] exp_out();
    int k, ph;
    logic [2:0] s;
    logic c;
    if (m_t < 0) return 6'b0;
    if (m_t == 2 * BEAT) return 6'b100000;
    k  = m_t / BEAT;
    ph = m_t % BEAT;
    s  = (k == 0) ? m_n[2:0] : {^m_n, 1'b1, m_n[3]};
    c  = (ph >= S) && (ph < S + ST);
    return {1'b0, 1'b1, c, s};
  endfunction

  task automatic tick();
    @(posedge hwclk);
    if (rst) begin
      m_t = -1;
      m_armed = 1'b0;
    end else if (m_t >= 0) begin
      m_t++;
      if (m_t > 2 * BEAT) m_t = -1;
    end else if (en && m_armed) begin
      m_t = 0;
      m_n = num;
      m_armed = 1'b0;
    end else if (!en) begin
      m_armed = 1'b1;
    end
    #1;
  endtask

  task automatic drain();
    en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_out()) begin
        n_fail++;
        $display("FAIL drain obs=%b exp=%b", obs, exp_out());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; num = 4'd0;
    tick(); tick();
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state obs=%b exp=000000", obs);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int act_n, done_n;
    logic [2:0] b0, b1;
    act_n = 0; done_n = 0; b0 = 'x; b1 = 'x;
    drain();
    en = 1'b1; num = 4'd5;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 1) en = 1'b0;
      act_n += int'(active);
      done_n += int'(done);
      if (m_t == 0) b0 = obs[2:0];
      if (m_t == BEAT) b1 = obs[2:0];
      n_checks++;
      if (obs !== exp_out()) begin
        n_fail++;
        $display("FAIL basic t=%0d obs=%b exp=%b", m_t, obs, exp_out());
      end
    end
    n_checks++;
    if (b0 !== 3'b101 || b1 !== 3'b010) begin
      n_fail++;
      $display("FAIL basic_syms got %b/%b exp 101/010", b0, b1);
    end
    n_checks++;
    if (act_n != 10 || done_n != 1) begin
      n_fail++;
      $display("FAIL basic_len act=%0d done=%0d exp 10/1", act_n, done_n);
    end
  endtask

  task automatic test_sweep();
    logic [2:0] t0 [10] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100,
                            3'b101, 3'b110, 3'b111, 3'b000, 3'b001};
    logic [2:0] t1 [10] = '{3'b010, 3'b110, 3'b110, 3'b010, 3'b110,
                            3'b010, 3'b010, 3'b110, 3'b111, 3'b011};
    logic [2:0] b0, b1;
    for (int d = 0; d < 10; d++) begin
      en = 1'b0;
      tick();
      en = 1'b1; num = 4'(d);
      b0 = 'x; b1 = 'x;
      for (int i = 0; i < 12; i++) begin
        tick();
        en = 1'b0;
        if (m_t == 0) b0 = obs[2:0];
        if (m_t == BEAT) b1 = obs[2:0];
        n_checks++;
        if (obs !== exp_out()) begin
          n_fail++;
          $display("FAIL sweep d=%0d t=%0d obs=%b exp=%b",
                   d, m_t, obs, exp_out());
        end
      end
      n_checks++;
      if (b0 !== t0[d] || b1 !== t1[d]) begin
        n_fail++;
        $display("FAIL sweep_syms d=%0d got %b/%b exp %b/%b",
                 d, b0, b1, t0[d], t1[d]);
      end
    end
  endtask

  task automatic test_hold_enabled();
    int starts, dones;
    logic prev;
    starts = 0; dones = 0; prev = 1'b0;
    drain();
    en = 1'b1; num = 4'd6;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (active && !prev) starts++;
      prev = active;
      dones += int'(done);
      n_checks++;
      if (obs !== exp_out()) begin
        n_fail++;
        $display("FAIL hold_en t=%0d obs=%b exp=%b", m_t, obs, exp_out());
      end
    end
    n_checks++;
    if (starts != 1 || dones != 1) begin
      n_fail++;
      $display("FAIL hold_en_count starts=%0d dones=%0d exp 1/1",
               starts, dones);
    end
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    n_checks++;
    if (active !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm_start active=%b exp 1", active);
    end
    drain();
  endtask

  task automatic test_num_change();
    logic [2:0] b0, b1;
    b0 = 'x; b1 = 'x;
    drain();
    en = 1'b1; num = 4'd3;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m_t == 2) num = 4'd12;
      if (m_t == 0) b0 = obs[2:0];
      if (m_t == BEAT) b1 = obs[2:0];
      n_checks++;
      if (obs !== exp_out()) begin
        n_fail++;
        $display("FAIL numchg t=%0d obs=%b exp=%b", m_t, obs, exp_out());
      end
    end
    n_checks++;
    if (b0 !== 3'b011 || b1 !== 3'b010) begin
      n_fail++;
      $display("FAIL numchg_syms got %b/%b exp 011/010", b0, b1);
    end
  endtask

  task automatic test_reset_midframe();
    drain();
    en = 1'b1; num = 4'd8;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_reset obs=%b exp=000000", obs);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs !== 6'b0) begin
        n_fail++;
        $display("FAIL post_reset obs=%b exp=000000", obs);
      end
    end
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    n_checks++;
    if (obs !== exp_out() || active !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rearm obs=%b exp=%b", obs, exp_out());
    end
    drain();
  endtask

  task automatic test_reset_release_enabled();
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (active !== 1'b0 || obs !== exp_out()) begin
        n_fail++;
        $display("FAIL release_en obs=%b exp=%b", obs, exp_out());
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(199) == 0);
      en  = ($urandom_range(3) != 0);
      num = 4'($urandom_range(15));
      tick();
      n_checks++;
      if (obs !== exp_out()) begin
        n_fail++;
        $display("FAIL random i=%0d t=%0d obs=%b exp=%b",
                 i, m_t, obs, exp_out());
      end
    end
    rst = 1'b0;
    drain();
  endtask

  initial begin
    m_t = -1; m_armed = 1'b0; m_n = 4'd0;
    rst = 1'b1; en = 1'b0; num = 4'd0;
    test_reset();
    test_basic();
    test_sweep();
    test_hold_enabled();
    test_num_change();
    test_reset_midframe();
    test_reset_release_enabled();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
